// File: rtl/sweep_scheduler.sv
// Frequency-stepped sounding sequencer for the AD9911 signal generator: loads each tuning word,
// waits for both DDS to confirm, then fires REPEAT_NUM GEN pulse trains before stepping on.
module sweep_scheduler #(
   parameter int unsigned SETTLE_CYCLES  = 100,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic        CLOCK_10M,
   input  logic        RESET_N,
   input  logic        START,
   input  logic        ABORT,
   input  logic [31:0] START_FREQW,
   input  logic [31:0] STEP_FREQW,
   input  logic [15:0] STEP_NUM,
   input  logic [7:0]  REPEAT_NUM,
   input  logic        INIT_OK,
   input  logic        FREQW_UPDATE_OVER,
   input  logic        GEN_OVER,
   output logic [31:0] FREQW,
   output logic        FREQW_UPDATE,
   output logic        GEN,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR,
   output logic [15:0] CUR_STEP,
   output logic [7:0]  CUR_REPEAT
);

   localparam logic [23:0] SETTLE_LAST  = 24'(SETTLE_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_INIT,
      S_F_REQ,
      S_F_ACK,
      S_F_DONE,
      S_SETTLE,
      S_G_REQ,
      S_G_ACK,
      S_G_DONE,
      S_NEXT
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [31:0] freqw_q, freqw_d;
   logic [31:0] step_freqw_q, step_freqw_d;
   logic [15:0] step_num_q, step_num_d;
   logic [7:0]  repeat_max_q, repeat_max_d;
   logic [15:0] cur_step_q, cur_step_d;
   logic [7:0]  cur_repeat_q, cur_repeat_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        timeout_hit;

   assign timeout_hit = (timer_q == TIMEOUT_LAST);

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
      state_d      = state_q;
      freqw_d      = freqw_q;
      step_freqw_d = step_freqw_q;
      step_num_d   = step_num_q;
      repeat_max_d = repeat_max_q;
      cur_step_d   = cur_step_q;
      cur_repeat_d = cur_repeat_q;
      error_d      = error_q;
      done_d       = 1'b0;

      // Abort wins over every transition, including a timeout or step update in the same cycle.
      if (ABORT && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  error_d = 1'b0;
                  if (STEP_NUM == 16'd0) begin
                     done_d = 1'b1;
                  end else begin
                     freqw_d      = START_FREQW;
                     step_freqw_d = STEP_FREQW;
                     step_num_d   = STEP_NUM;
                     repeat_max_d = (REPEAT_NUM == 8'd0) ? 8'd1 : REPEAT_NUM;
                     cur_step_d   = 16'd0;
                     cur_repeat_d = 8'd0;
                     state_d      = S_WAIT_INIT;
                  end
               end
            end
            S_WAIT_INIT: begin
               if (INIT_OK) begin
                  state_d = S_F_REQ;
               end else if (timeout_hit) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end
            end
            S_F_REQ: state_d = S_F_ACK;
            S_F_ACK: begin
               if (!FREQW_UPDATE_OVER) begin
                  state_d = S_F_DONE;
               end else if (timeout_hit) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end
            end
            S_F_DONE: begin
               if (FREQW_UPDATE_OVER) begin
                  state_d      = S_SETTLE;
                  cur_repeat_d = 8'd0;
               end else if (timeout_hit) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end
            end
            S_SETTLE: begin
               if (timer_q == SETTLE_LAST) begin
                  state_d = S_G_REQ;
               end
            end
            S_G_REQ: state_d = S_G_ACK;
            S_G_ACK: begin
               if (!GEN_OVER) begin
                  state_d = S_G_DONE;
               end else if (timeout_hit) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end
            end
            S_G_DONE: begin
               if (GEN_OVER) begin
                  state_d = S_NEXT;
               end else if (timeout_hit) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end
            end
            S_NEXT: begin
               if (({1'b0, cur_repeat_q} + 9'd1) < {1'b0, repeat_max_q}) begin
                  cur_repeat_d = cur_repeat_q + 8'd1;
                  state_d      = S_G_REQ;
               end else if (({1'b0, cur_step_q} + 17'd1) < {1'b0, step_num_q}) begin
                  cur_step_d = cur_step_q + 16'd1;
                  freqw_d    = freqw_q + step_freqw_q;
                  state_d    = S_F_REQ;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Shared settle/timeout counter restarts on every state entry.
      timer_d = ((state_d == state_q) && (state_q != S_IDLE)) ? timer_q + 24'd1 : 24'd0;
   end

   always_ff @(posedge CLOCK_10M) begin
      // NOTE: reset is sampled on the clock edge; nonblocking updates so all registers see pre-edge values.
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         timer_q      <= 24'd0;
         freqw_q      <= 32'd0;
         step_freqw_q <= 32'd0;
         step_num_q   <= 16'd0;
         repeat_max_q <= 8'd0;
         cur_step_q   <= 16'd0;
         cur_repeat_q <= 8'd0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         freqw_q      <= freqw_d;
         step_freqw_q <= step_freqw_d;
         step_num_q   <= step_num_d;
         repeat_max_q <= repeat_max_d;
         cur_step_q   <= cur_step_d;
         cur_repeat_q <= cur_repeat_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign FREQW        = freqw_q;
   assign FREQW_UPDATE = (state_q == S_F_REQ);
   assign GEN          = (state_q == S_G_REQ);
   assign BUSY         = (state_q != S_IDLE);
   assign DONE         = done_q;
   assign ERROR        = error_q;
   assign CUR_STEP     = cur_step_q;
   assign CUR_REPEAT   = cur_repeat_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Self-checking bench for sweep_scheduler: a signal-generator responder plus an event monitor,
// with every recorded sweep compared against tuning words and pulse counts derived from the config.
module tb_sweep_scheduler;

   localparam int SETTLE  = 100;
   localparam int TIMEOUT = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, init_ok, fu_over, gen_over;
   logic [31:0] start_freqw, step_freqw;
   logic [15:0] step_num;
   logic [7:0]  repeat_num;
   logic [31:0] freqw;
   logic        fu, gen, busy, done, error;
   logic [15:0] cur_step;
   logic [7:0]  cur_repeat;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   string cur_test = "init";

   int f_lo = 2, f_hi = 2, g_lo = 2, g_hi = 2;
   bit gen_ack_en = 1'b1;
   bit mon_clear = 1'b0;
   int fd, gd;

   typedef struct {
      int          step;
      int          rep;
      logic [31:0] fw;
      int          cyc;
   } gen_rec_t;

   logic [31:0] fu_fw_q[$];
   int          fu_cyc_q[$];
   gen_rec_t    gen_q[$];
   int          done_cnt, done_cyc, err_cyc, busy_seen, back2back;
   int          start_cyc;

   sweep_scheduler #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .CLOCK_10M(clk), .RESET_N(rst_n), .START(start), .ABORT(abort),
      .START_FREQW(start_freqw), .STEP_FREQW(step_freqw), .STEP_NUM(step_num),
      .REPEAT_NUM(repeat_num), .INIT_OK(init_ok), .FREQW_UPDATE_OVER(fu_over),
      .GEN_OVER(gen_over), .FREQW(freqw), .FREQW_UPDATE(fu), .GEN(gen), .BUSY(busy),
      .DONE(done), .ERROR(error), .CUR_STEP(cur_step), .CUR_REPEAT(cur_repeat)
   );

   always #50 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", cur_test, tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // DDS update responder: drops the level on request, restores it after a delay.
   initial begin
      fu_over = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (fu === 1'b1) begin
            fu_over = 1'b0;
            fd = int'($urandom_range(f_hi, f_lo));
            repeat (fd) begin @(posedge clk); #1; end
            fu_over = 1'b1;
         end
      end
   end

   // Pulse-train responder; can be disabled to leave GEN unacknowledged.
   initial begin
      gen_over = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (gen === 1'b1 && gen_ack_en) begin
            gen_over = 1'b0;
            gd = int'($urandom_range(g_hi, g_lo));
            repeat (gd) begin @(posedge clk); #1; end
            gen_over = 1'b1;
         end
      end
   end

   // Event monitor: records every request, completion and error edge.
   initial begin
      gen_rec_t r;
      logic prev_req, err_prev;
      prev_req = 1'b0;
      err_prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mon_clear) begin
            fu_fw_q.delete(); fu_cyc_q.delete(); gen_q.delete();
            done_cnt = 0; done_cyc = -1; err_cyc = -1; busy_seen = 0; back2back = 0;
         end
         if (fu) begin
            fu_fw_q.push_back(freqw);
            fu_cyc_q.push_back(cyc);
         end
         if (gen) begin
            r.step = int'(cur_step); r.rep = int'(cur_repeat); r.fw = freqw; r.cyc = cyc;
            gen_q.push_back(r);
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (error && !err_prev) err_cyc = cyc;
         err_prev = error;
         if (busy) busy_seen = 1;
         if ((fu || gen) && prev_req) back2back++;
         if (fu && gen) back2back++;
         prev_req = fu || gen;
      end
   end

   task automatic clear_mon();
      mon_clear = 1'b1;
      idle(2);
      mon_clear = 1'b0;
   endtask

   task automatic start_sweep(input logic [31:0] sf, input logic [31:0] st, input int n, input int rep);
      start_freqw = sf; step_freqw = st; step_num = 16'(n); repeat_num = 8'(rep);
      start = 1'b1; start_cyc = cyc;
      tick();
      start = 1'b0;
      // Latched config must not follow later input changes, nor a START while busy.
      start_freqw = $urandom; step_freqw = $urandom;
      step_num = 16'($urandom); repeat_num = 8'($urandom);
      if (n != 0) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
   endtask

   task automatic wait_end(input int budget);
      bit ended;
      ended = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done || error) begin ended = 1'b1; break; end
         tick();
      end
      check("sweep_end_reached", ended, 1);
      idle(3);
   endtask

   // Expected sweep: FREQW(s) = sf + s*st mod 2^32, max(rep,1) GEN pulses per step in order.
   task automatic check_sweep(input logic [31:0] sf, input logic [31:0] st, input int n,
                              input int rep, input bit timed);
      int reps;
      logic [31:0] fw;
      reps = (rep == 0) ? 1 : rep;
      check("fu_count", fu_fw_q.size(), n);
      check("gen_count", gen_q.size(), n * reps);
      check("done_count", done_cnt, 1);
      check("error_flag", error, 0);
      check("busy_after", busy, 0);
      check("no_back_to_back", back2back, 0);
      for (int s = 0; s < n && s < fu_fw_q.size(); s++) begin
         fw = sf + st * 32'(s);
         check("fu_freqw", fu_fw_q[s], fw);
         if (timed && s > 0 && s * reps - 1 < gen_q.size())
            check("step_gap", fu_cyc_q[s] - gen_q[s*reps-1].cyc, g_lo + 2);
      end
      for (int i = 0; i < n * reps && i < gen_q.size(); i++) begin
         fw = sf + st * 32'(i / reps);
         check("gen_step", gen_q[i].step, i / reps);
         check("gen_repeat", gen_q[i].rep, i % reps);
         check("gen_freqw", gen_q[i].fw, fw);
         if (timed) begin
            // Ack edge + 1 cycle to leave F_DONE, SETTLE idle cycles, then the GEN request.
            if (i % reps == 0 && i / reps < fu_cyc_q.size())
               check("settle_gap", gen_q[i].cyc - fu_cyc_q[i/reps], f_lo + SETTLE + 1);
            else if (i % reps != 0)
               check("gen_gap", gen_q[i].cyc - gen_q[i-1].cyc, g_lo + 2);
         end
      end
      if (timed && gen_q.size() > 0)
         check("done_gap", done_cyc - gen_q[gen_q.size()-1].cyc, g_lo + 2);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_freqw"}, freqw, 0);
      check({tag, "_flags"}, {fu, gen, busy, done, error}, 0);
      check({tag, "_cur"}, {cur_step, cur_repeat}, 0);
   endtask

   initial begin
      #(100 * 80000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sf, st;
      int n, rep;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; init_ok = 1'b1;
      start_freqw = '0; step_freqw = '0; step_num = '0; repeat_num = '0;

      cur_test = "reset";
      idle(3);
      check_all_zero("in_reset");
      rst_n = 1'b1;
      idle(2);
      check_all_zero("after_reset");

      cur_test = "basic";
      f_lo = 40; f_hi = 40; g_lo = 40; g_hi = 40;
      clear_mon();
      start_sweep(32'h1000_0000, 32'h0100_0000, 3, 2);
      wait_end(5000);
      check("start_to_fu", fu_cyc_q.size() > 0 ? fu_cyc_q[0] - start_cyc : -1, 2);
      check_sweep(32'h1000_0000, 32'h0100_0000, 3, 2, 1'b1);

      cur_test = "zero_steps";
      f_lo = 2; f_hi = 12; g_lo = 2; g_hi = 12;
      clear_mon();
      start_sweep(32'h1234_5678, 32'h1, 0, 2);
      wait_end(10);
      check("done_latency", done_cyc - start_cyc, 1);
      check("done_count", done_cnt, 1);
      check("no_requests", fu_fw_q.size() + gen_q.size(), 0);
      check("busy_never", busy_seen, 0);

      cur_test = "zero_repeat";
      clear_mon();
      start_sweep(32'h0000_0040, 32'h0000_0010, 2, 0);
      wait_end(5000);
      check_sweep(32'h0000_0040, 32'h0000_0010, 2, 0, 1'b0);

      cur_test = "wrap";
      clear_mon();
      start_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 1);
      wait_end(5000);
      check_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 1, 1'b0);
      if (fu_fw_q.size() > 1) check("wrapped_word", fu_fw_q[1], 32'h0000_0100);
      else check("wrapped_present", fu_fw_q.size(), 2);

      cur_test = "timeout";
      gen_ack_en = 1'b0;
      clear_mon();
      start_sweep(32'h2000_0000, 32'h1, 1, 1);
      wait_end(3000);
      check("err_flag", error, 1);
      check("err_busy", busy, 0);
      check("err_no_done", done_cnt, 0);
      check("err_gen_count", gen_q.size(), 1);
      if (gen_q.size() > 0) check("err_delay", err_cyc - gen_q[0].cyc, TIMEOUT + 1);
      gen_ack_en = 1'b1;
      clear_mon();
      start_sweep(32'h3000_0000, 32'h10, 2, 1);
      check("err_cleared", error, 0);
      wait_end(5000);
      check_sweep(32'h3000_0000, 32'h10, 2, 1, 1'b0);

      cur_test = "abort";
      g_lo = 30; g_hi = 30;
      clear_mon();
      start_sweep(32'h4000_0000, 32'h100, 3, 2);
      for (int i = 0; i < 3000 && gen_q.size() == 0; i++) tick();
      idle(5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      idle(300);
      check("abort_gen_count", gen_q.size(), 1);
      check("abort_fu_count", fu_fw_q.size(), 1);
      check("abort_no_done", done_cnt, 0);
      check("abort_error", error, 0);
      check("abort_freqw_held", freqw, 32'h4000_0000);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      idle(2);
      check("idle_abort_ignored", {busy, done, error}, 0);
      check("idle_abort_freqw", freqw, 32'h4000_0000);

      cur_test = "reset_mid_settle";
      g_lo = 2; g_hi = 12; f_lo = 5; f_hi = 5;
      clear_mon();
      start_freqw = 32'h5000_0000; step_freqw = 32'h1; step_num = 16'd2; repeat_num = 8'd1;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_beats_abort", busy, 1);
      for (int i = 0; i < 100 && fu_fw_q.size() == 0; i++) tick();
      idle(20);
      check("in_settle_no_gen", gen_q.size(), 0);
      rst_n = 1'b0;
      tick();
      check_all_zero("mid_reset");
      rst_n = 1'b1;
      idle(300);
      check("post_reset_gen", gen_q.size(), 0);
      check("post_reset_done", done_cnt, 0);
      check("post_reset_busy", busy, 0);

      cur_test = "init_wait";
      f_lo = 2; f_hi = 12;
      init_ok = 1'b0;
      clear_mon();
      start_sweep(32'h6000_0000, 32'h20, 2, 1);
      idle(500);
      check("no_fu_before_init", fu_fw_q.size(), 0);
      check("busy_waiting_init", busy, 1);
      init_ok = 1'b1;
      n = cyc;
      wait_end(5000);
      check("init_to_fu", fu_cyc_q.size() > 0 ? fu_cyc_q[0] - n : -1, 1);
      check_sweep(32'h6000_0000, 32'h20, 2, 1, 1'b0);

      for (int t = 0; t < 6; t++) begin
         cur_test = $sformatf("random%0d", t);
         sf = $urandom; st = $urandom;
         n = int'($urandom_range(4, 1)); rep = int'($urandom_range(3, 0));
         f_lo = 2; f_hi = int'($urandom_range(20, 2));
         g_lo = 2; g_hi = int'($urandom_range(20, 2));
         clear_mon();
         start_sweep(sf, st, n, rep);
         wait_end(20000);
         check_sweep(sf, st, n, rep, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
